bram_arb: RTL and testbench
===========================

# bram_arb

Two-port arbiter plus 16-bit single-port block RAM sitting directly downstream of the MCU BRAM bridge. It consumes the bridge's MemBus, word writes/reads and byte-lane enables, and returns its 16-bit read word. It also serves a console-side (68k) port sharing the same RAM. The MCU port gets bounded latency so the bridge's fixed `MEM_TIME` sampling always sees valid data.

## Interface
- ADDR_W, 16: byte-address width; RAM depth 2^(ADDR_W-1) words, indexed by addr[ADDR_W-1:1]; addr[0] ignored
- MEM_TIME, `MEM_TIME: bridge sampling delay; elaboration error if < ARB_MIN_MEM_TIME (5)

One clock; reset is asynchronous and active-high. Ports:
- clk  in  1  system clock (same as MCU bus clock)
- rst  in  1  asynchronous, active-high reset
- mem  in  MemBus  MCU-side request from the bridge: dati[15:0], addr, oe, we[1:0] (we[1]=upper byte)
- mem_dato  out  16  MCU read word, to the bridge
- cpu_addr  in  ADDR_W  console byte address
- cpu_dati  in  16  console write word
- cpu_we  in  2  console byte-lane write enables; 0 = read
- cpu_stb  in  1  one-cycle request strobe; addr/dati/we sampled with it
- cpu_dato  out  16  console read word, valid while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- cpu_ovf  out  1  sticky: strobe arrived while a console request was pending

## Operation
- MCU request level `mreq` = mem.oe | (|mem.we). A new MCU request is a rising edge of `mreq`, or an address change while `mreq` stays high; it sets mcu_pend. Each request is serviced exactly once, and a held level does not retrigger.
- Write-vs-read: if any we bit is set, the access is a write using the byte lanes and mem_dato is unchanged; otherwise it is a read.
- cpu_stb latches addr/data/we into a holding register and sets cpu_pend. A strobe while cpu_pend=1 is dropped and sets cpu_ovf, which is cleared only by rst.
- FSM states: IDLE, CPU_CAP, MCU_CAP.
  - IDLE: if both are pending, grant CPU unless last_cpu=1, then grant MCU. Otherwise grant whichever is pending. The grant drives the RAM in the same cycle (registered read issued) and moves to the *_CAP state; the granted pend flag clears.
  - CPU_CAP: RAM q goes to cpu_dato (reads); assert cpu_ack next cycle for reads and writes; set last_cpu=1; go to IDLE.
  - MCU_CAP: on a read, RAM q goes to mem_dato; set last_cpu=0; go to IDLE.
- No issue in a *_CAP state. Throughput is one access per 2 cycles.
- Reset: state IDLE, pend flags 0, last_cpu 0, mem_dato=0, cpu_dato=0, cpu_ack=0, cpu_ovf=0. RAM contents are not reset.
- Reset mid-access: the in-flight access is abandoned. A RAM write already clocked stays written; no ack is produced.
- A new cpu_stb in the cycle cpu_pend clears (grant cycle) is accepted; it is not an overflow.

## Timing
- CPU: strobe at T, pend visible at T+1, issue at T+1 if IDLE wins, capture at T+2, cpu_ack/cpu_dato high at T+3 for exactly 1 cycle. Best-case latency is 3; worst case is 5 (an MCU access in flight).
- MCU: request visible at T, issue at T if IDLE and granted, mem_dato valid at T+2. Worst case is a CPU access issued at T, then MCU issue at T+2 and mem_dato valid at T+4. This bound is why MEM_TIME ≥ 5.
- mem_dato and cpu_dato are registered and hold until the next read of their own port completes.
- cpu_ack never pulses on back-to-back cycles.

## Structure
- The shared package holds MemBus (existing), ARB_MIN_MEM_TIME=5, and the arb_state_t enum.
- Sub-module bram_sp: single-port 16-bit RAM with 2 byte-lane write enables and a registered read (1-cycle), for inference. The arbiter FSM, pend logic and edge detect live in bram_arb.

## Test plan
- MCU write 0xBEEF at 0x0010, we=2'b11; then MCU read 0x0010 → mem_dato=0xBEEF two cycles after the read request becomes visible.
- CPU byte write 0x12xx with we=2'b10 at 0x0010 after the above; CPU read → cpu_ack pulses once 3 cycles after strobe, cpu_dato=0x12EF.
- MCU read and cpu_stb in the same cycle with last_cpu=0 → CPU served first, mem_dato valid exactly 4 cycles after the MCU request. A following simultaneous pair is served MCU-first.
- Bridge-style sequence holding oe high while addr steps 0x0020→0x0022 → two reads, each serviced once. mem_dato shows word 0x0020 then word 0x0022.
- Two cpu_stb 1 cycle apart while an MCU access is in flight → second strobe dropped, cpu_ovf=1 and stays 1, exactly one cpu_ack.
- Assert rst during CPU_CAP → cpu_ack never pulses; all outputs 0 the next cycle; a new access after release completes normally.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types for the MCU/console BRAM arbiter: bridge MemBus, arbiter state
// and the holding-register request format.
`ifndef MEM_TIME
`define MEM_TIME 5
`endif

package bram_arb_pkg;
  localparam int MEM_AW           = 16;
  localparam int ARB_MIN_MEM_TIME = 5;

  typedef struct packed {
    logic [15:0]       dati;
    logic [MEM_AW-1:0] addr;
    logic              oe;
    logic [1:0]        we;   // we[1] = upper byte
  } MemBus;

  typedef enum logic [1:0] {IDLE, CPU_CAP, MCU_CAP} arb_state_t;

  typedef struct packed {
    logic [MEM_AW-2:0] wa;
    logic [15:0]       dat;
    logic [1:0]        we;
  } arb_req_t;

  function automatic arb_req_t mk_req(logic [MEM_AW-2:0] wa, logic [15:0] dat,
                                      logic [1:0] we);
    arb_req_t r;
    r.wa  = wa;
    r.dat = dat;
    r.we  = we;
    return r;
  endfunction
endpackage

// File: rtl/bram_arb_sp.sv
// Single-port 16-bit RAM, two byte-lane write enables, 1-cycle registered read.
module bram_sp #(
  parameter int AW = 15
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [AW-1:0] addr_i,
  input  logic [1:0]    we_i,
  input  logic [15:0]   d_i,
  output logic [15:0]   q_o
);
  logic [15:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i[0]) mem_q[addr_i][7:0]  <= d_i[7:0];
      if (we_i[1]) mem_q[addr_i][15:8] <= d_i[15:8];
      q_o <= mem_q[addr_i];
    end
  end
endmodule

// File: rtl/bram_arb.sv
// Two-port arbiter in front of a shared 16-bit BRAM: MCU bridge port with
// bounded latency, console port with strobe/ack handshake.
module bram_arb
  import bram_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int MEM_TIME = `MEM_TIME
) (
  input  logic              clk,
  input  logic              rst,
  input  MemBus             mem,
  output logic [15:0]       mem_dato,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_dati,
  input  logic [1:0]        cpu_we,
  input  logic              cpu_stb,
  output logic [15:0]       cpu_dato,
  output logic              cpu_ack,
  output logic              cpu_ovf
);
  localparam int WA = ADDR_W - 1;

  if (MEM_TIME < ARB_MIN_MEM_TIME) begin : g_mem_time_chk
    $error("bram_arb: MEM_TIME too small for worst-case MCU latency");
  end
  if (ADDR_W > MEM_AW || ADDR_W < 2) begin : g_addr_w_chk
    $error("bram_arb: ADDR_W out of range");
  end

  arb_state_t        state_q;
  logic              mreq, mreq_q, mcu_new;
  logic [ADDR_W-1:0] maddr_q;
  logic              mcu_pend_q, cpu_pend_q, last_cpu_q, rd_q;
  arb_req_t          mcu_hold_q, cpu_hold_q, sel;
  logic              gnt_cpu, gnt_mcu;
  logic [15:0]       ram_q;
  logic              unused_addr_lsb;

  assign unused_addr_lsb = cpu_addr[0];

  // A held request level only retriggers when the bridge moves the address.
  assign mreq    = mem.oe | (|mem.we);
  assign mcu_new = mreq & (~mreq_q | (mem.addr[ADDR_W-1:0] != maddr_q));

  always_comb begin
    gnt_cpu = 1'b0;
    gnt_mcu = 1'b0;
    if (state_q == IDLE) begin
      if (cpu_pend_q && mcu_pend_q) begin
        gnt_cpu = ~last_cpu_q;
        gnt_mcu = last_cpu_q;
      end else begin
        gnt_cpu = cpu_pend_q;
        gnt_mcu = mcu_pend_q;
      end
    end
    sel = gnt_cpu ? cpu_hold_q : mcu_hold_q;
  end

  bram_sp #(.AW(WA)) u_ram (
    .clk    (clk),
    .en_i   (gnt_cpu | gnt_mcu),
    .addr_i (sel.wa[WA-1:0]),
    .we_i   (sel.we),
    .d_i    (sel.dat),
    .q_o    (ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mreq_q     <= 1'b0;
      maddr_q    <= '0;
      mcu_pend_q <= 1'b0;
      cpu_pend_q <= 1'b0;
      last_cpu_q <= 1'b0;
      rd_q       <= 1'b0;
      mcu_hold_q <= '0;
      cpu_hold_q <= '0;
      mem_dato   <= '0;
      cpu_dato   <= '0;
      cpu_ack    <= 1'b0;
      cpu_ovf    <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      mreq_q  <= mreq;
      maddr_q <= mem.addr[ADDR_W-1:0];

      if (mcu_new) begin
        mcu_hold_q <= mk_req((MEM_AW-1)'(mem.addr[ADDR_W-1:1]), mem.dati, mem.we);
        mcu_pend_q <= 1'b1;
      end else if (gnt_mcu) begin
        mcu_pend_q <= 1'b0;
      end

      // The grant cycle frees the holding register, so a strobe there is accepted.
      if (cpu_stb && cpu_pend_q && !gnt_cpu) begin
        cpu_ovf <= 1'b1;
      end else if (cpu_stb) begin
        cpu_hold_q <= mk_req((MEM_AW-1)'(cpu_addr[ADDR_W-1:1]), cpu_dati, cpu_we);
        cpu_pend_q <= 1'b1;
      end else if (gnt_cpu) begin
        cpu_pend_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (gnt_cpu || gnt_mcu) begin
            state_q <= gnt_cpu ? CPU_CAP : MCU_CAP;
            rd_q    <= ~|sel.we;
          end
        end
        CPU_CAP: begin
          if (rd_q) cpu_dato <= ram_q;
          cpu_ack    <= 1'b1;
          last_cpu_q <= 1'b1;
          state_q    <= IDLE;
        end
        MCU_CAP: begin
          if (rd_q) mem_dato <= ram_q;
          last_cpu_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_arb.sv
// Directed bench for bram_arb: RAM/byte-lane model plus cycle-stamped
// scoreboards for cpu_ack/cpu_dato and mem_dato.
module tb_bram_arb;
  import bram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  MemBus       mem_s;
  logic [15:0] mem_dato, cpu_dato, cpu_dati;
  logic [15:0] cpu_addr;
  logic [1:0]  cpu_we;
  logic        cpu_stb, cpu_ack, cpu_ovf;

  bram_arb #(.ADDR_W(16), .MEM_TIME(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem      (mem_s),
    .mem_dato (mem_dato),
    .cpu_addr (cpu_addr),
    .cpu_dati (cpu_dati),
    .cpu_we   (cpu_we),
    .cpu_stb  (cpu_stb),
    .cpu_dato (cpu_dato),
    .cpu_ack  (cpu_ack),
    .cpu_ovf  (cpu_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] dat;
  } exp_t;

  exp_t        cq[$];
  exp_t        mq[$];
  logic [15:0] ram_m [int];
  logic [15:0] cdato_m = 16'h0;
  logic [15:0] mdato_m = 16'h0;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic logic [15:0] lanes(logic [15:0] old, logic [15:0] d, logic [1:0] w);
    return {w[1] ? d[15:8] : old[15:8], w[0] ? d[7:0] : old[7:0]};
  endfunction

  function automatic logic [15:0] rd_m(logic [15:0] a);
    int k = int'(a >> 1);
    return ram_m.exists(k) ? ram_m[k] : 16'h0;
  endfunction

  function automatic void wr_m(logic [15:0] a, logic [15:0] d, logic [1:0] w);
    int k = int'(a >> 1);
    ram_m[k] = lanes(rd_m(a), d, w);
  endfunction

  // Console scoreboard: every ack must match the oldest expected entry in cycle and data.
  always @(negedge clk) begin
    exp_t e;
    if (cpu_ack) begin
      n_chk++;
      assert (cq.size() > 0) else begin
        n_fail++;
        $error("FAIL cpu_ack_unexpected: ack at cyc %0d, required none", cyc);
      end
      if (cq.size() > 0) begin
        e = cq.pop_front();
        n_chk++;
        assert (cyc === e.cyc && cpu_dato === e.dat) else begin
          n_fail++;
          $error("FAIL cpu_ack: cyc %0d dato %h, required cyc %0d dato %h", cyc, cpu_dato, e.cyc, e.dat);
        end
      end
    end
  end

  // MCU scoreboard: mem_dato checked at exact cycles.
  always @(negedge clk) begin
    exp_t m;
    while (mq.size() > 0 && mq[0].cyc <= cyc) begin
      m = mq.pop_front();
      n_chk++;
      assert (m.cyc == cyc && mem_dato === m.dat) else begin
        n_fail++;
        $error("FAIL mem_dato: cyc %0d got %h, required %h at cyc %0d", cyc, mem_dato, m.dat, m.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h, required %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_set(input logic [15:0] a, input logic [15:0] d, input logic [1:0] w,
                         input int lat, input bit push);
    cpu_addr = a; cpu_dati = d; cpu_we = w; cpu_stb = 1'b1;
    if (push) begin
      if (w == 2'b00) cdato_m = rd_m(a);
      else wr_m(a, d, w);
      cq.push_back('{cyc + lat, cdato_m});
    end
  endtask

  task automatic cpu_clr();
    cpu_stb = 1'b0; cpu_we = 2'b00;
  endtask

  task automatic mcu_set(input logic [15:0] a, input logic [15:0] d, input logic [1:0] w,
                         input int lat);
    mem_s.addr = a; mem_s.dati = d; mem_s.we = w; mem_s.oe = (w == 2'b00);
    if (w == 2'b00) begin
      mq.push_back('{cyc + lat - 1, mdato_m});
      mdato_m = rd_m(a);
    end else begin
      wr_m(a, d, w);
    end
    mq.push_back('{cyc + lat, mdato_m});
  endtask

  task automatic mcu_clr();
    mem_s.oe = 1'b0; mem_s.we = 2'b00;
  endtask

  task automatic cpu_req(input logic [15:0] a, input logic [15:0] d, input logic [1:0] w);
    cpu_set(a, d, w, 3, 1'b1); tick(); cpu_clr(); wait_n(6);
  endtask

  task automatic mcu_req(input logic [15:0] a, input logic [15:0] d, input logic [1:0] w);
    mcu_set(a, d, w, 3); tick(); mcu_clr(); wait_n(6);
  endtask

  initial begin
    rst = 1'b1;
    mem_s = '0;
    cpu_addr = '0; cpu_dati = '0; cpu_we = '0; cpu_stb = 1'b0;
    wait_n(3);
    chk("rst_mem_dato", mem_dato, 16'h0);
    chk("rst_cpu_dato", cpu_dato, 16'h0);
    chk("rst_cpu_ack", {15'h0, cpu_ack}, 16'h0);
    chk("rst_cpu_ovf", {15'h0, cpu_ovf}, 16'h0);
    rst = 1'b0;
    wait_n(2);

    // MCU full write then read-back; CPU upper-byte write then read.
    mcu_req(16'h0010, 16'hBEEF, 2'b11);
    mcu_req(16'h0010, 16'h0000, 2'b00);
    cpu_req(16'h0010, 16'h1234, 2'b10);
    cpu_req(16'h0010, 16'h0000, 2'b00);
    cpu_req(16'h0030, 16'hA5A5, 2'b11);
    mcu_req(16'h0010, 16'h0000, 2'b00);

    // Simultaneous pair with last_cpu=0: CPU first, MCU data 2 cycles late.
    cpu_set(16'h0010, 16'h0, 2'b00, 3, 1'b1);
    mcu_set(16'h0030, 16'h0, 2'b00, 5);
    tick(); cpu_clr(); mcu_clr(); wait_n(8);

    // After a console access, the next simultaneous pair goes MCU first.
    cpu_req(16'h0020, 16'h1111, 2'b11);
    cpu_set(16'h0030, 16'h0, 2'b00, 5, 1'b1);
    mcu_set(16'h0020, 16'h0, 2'b00, 3);
    tick(); cpu_clr(); mcu_clr(); wait_n(8);

    cpu_req(16'h0022, 16'h2222, 2'b11);
    mcu_req(16'h0010, 16'h0000, 2'b00);

    // Bridge holds oe high and steps the address; a held level must not retrigger.
    mcu_set(16'h0020, 16'h0, 2'b00, 3);
    wait_n(6);
    mcu_set(16'h0022, 16'h0, 2'b00, 3);
    wait_n(6);
    cpu_set(16'h0020, 16'h0, 2'b00, 3, 1'b1);
    tick(); cpu_clr(); wait_n(6);
    mcu_clr(); wait_n(2);

    // Second strobe while the first is pending behind an MCU access is dropped.
    mcu_set(16'h0030, 16'h0, 2'b00, 3);
    tick(); mcu_clr();
    cpu_set(16'h0022, 16'h0, 2'b00, 4, 1'b1);
    tick();
    cpu_set(16'h0020, 16'h0, 2'b00, 0, 1'b0);
    tick(); cpu_clr();
    chk("ovf_set", {15'h0, cpu_ovf}, 16'h1);
    wait_n(8);
    chk("ovf_sticky", {15'h0, cpu_ovf}, 16'h1);

    // Reset while the console read sits in CPU_CAP: no ack, outputs cleared.
    cpu_set(16'h0010, 16'h0, 2'b00, 0, 1'b0);
    tick(); cpu_clr();
    tick();
    rst = 1'b1;
    tick();
    chk("rstmid_cpu_ack", {15'h0, cpu_ack}, 16'h0);
    chk("rstmid_mem_dato", mem_dato, 16'h0);
    chk("rstmid_cpu_dato", cpu_dato, 16'h0);
    chk("rstmid_cpu_ovf", {15'h0, cpu_ovf}, 16'h0);
    rst = 1'b0;
    cdato_m = 16'h0;
    mdato_m = 16'h0;
    wait_n(2);
    cpu_req(16'h0022, 16'h0000, 2'b00);
    mcu_req(16'h0010, 16'h0000, 2'b00);
    wait_n(4);

    chk("cpu_queue_drained", 16'(cq.size()), 16'h0);
    chk("mcu_queue_drained", 16'(mq.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
